// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: a direct-mapped BTB where each entry holds a
// valid bit, a tag, a target and a 2-bit saturating direction counter.
// Lookup is combinational on the fetch pc. Training comes from the EX-stage
// resolution of each branch or jump. Two performance counters are kept.
module branch_predictor #(
   parameter int unsigned IDX_BITS = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] if_pc,
   output logic        btb_hit,
   output logic        prediction,
   output logic [31:0] btb_out,
   input  logic        update_valid,
   input  logic [31:0] update_pc,
   input  logic        update_taken,
   input  logic [31:0] update_target,
   input  logic        mispredict,
   output logic [31:0] br_count,
   output logic [31:0] mispred_count
);

   localparam int unsigned TAG_BITS = 30 - IDX_BITS;
   localparam int unsigned ENTRIES  = 1 << IDX_BITS;

   logic [ENTRIES-1:0]  valid_q;
   logic [TAG_BITS-1:0] tag_q    [ENTRIES];
   logic [31:0]         target_q [ENTRIES];
   logic [1:0]          ctr_q    [ENTRIES];

   logic [31:0] br_count_q;
   logic [31:0] mispred_count_q;

   logic [IDX_BITS-1:0] lk_idx;
   logic [TAG_BITS-1:0] lk_tag;
   logic [IDX_BITS-1:0] upd_idx;
   logic [TAG_BITS-1:0] upd_tag;
   logic                upd_hit;

   function automatic logic [1:0] sat_inc(input logic [1:0] c);
      return (c == 2'b11) ? 2'b11 : c + 2'd1;
   endfunction

   function automatic logic [1:0] sat_dec(input logic [1:0] c);
      return (c == 2'b00) ? 2'b00 : c - 2'd1;
   endfunction

   // Combinational lookup; reads the pre-update array (no write bypass).
   always_comb begin
      lk_idx     = if_pc[IDX_BITS+1:2];
      lk_tag     = if_pc[31:IDX_BITS+2];
      btb_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
      prediction = btb_hit && ctr_q[lk_idx][1];
      btb_out    = prediction ? target_q[lk_idx] : if_pc + 32'd4;
   end

   // Decode the resolved instruction's index/tag and detect an entry hit.
   always_comb begin
      upd_idx = update_pc[IDX_BITS+1:2];
      upd_tag = update_pc[31:IDX_BITS+2];
      upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
   end

   // Valid bits: cleared by reset; set when a taken miss allocates.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (update_valid && update_taken && !upd_hit) begin
         valid_q[upd_idx] <= 1'b1;
      end
   end

   // Entry payload: train on hit, allocate on taken miss; not-taken misses ignored.
   always_ff @(posedge clk) begin
      if (!rst && update_valid) begin
         if (upd_hit) begin
            if (update_taken) begin
               ctr_q[upd_idx]    <= sat_inc(ctr_q[upd_idx]);
               target_q[upd_idx] <= update_target;
            end else begin
               ctr_q[upd_idx] <= sat_dec(ctr_q[upd_idx]);
            end
         end else if (update_taken) begin
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= update_target;
            ctr_q[upd_idx]    <= 2'b10;
         end
      end
   end

   // Performance counters; both wrap naturally at 32 bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         br_count_q      <= '0;
         mispred_count_q <= '0;
      end else if (update_valid) begin
         br_count_q <= br_count_q + 32'd1;
         if (mispredict) begin
            mispred_count_q <= mispred_count_q + 32'd1;
         end
      end
   end

   assign br_count      = br_count_q;
   assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] if_pc;
   logic        btb_hit;
   logic        prediction;
   logic [31:0] btb_out;
   logic        update_valid;
   logic [31:0] update_pc;
   logic        update_taken;
   logic [31:0] update_target;
   logic        mispredict;
   logic [31:0] br_count;
   logic [31:0] mispred_count;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   branch_predictor #(.IDX_BITS(5)) dut (
      .clk           (clk),
      .rst           (rst),
      .if_pc         (if_pc),
      .btb_hit       (btb_hit),
      .prediction    (prediction),
      .btb_out       (btb_out),
      .update_valid  (update_valid),
      .update_pc     (update_pc),
      .update_taken  (update_taken),
      .update_target (update_target),
      .mispredict    (mispredict),
      .br_count      (br_count),
      .mispred_count (mispred_count)
   );

   typedef struct {
      logic        upd;
      logic [31:0] upc;
      logic        utk;
      logic [31:0] utgt;
      logic        mis;
      logic [31:0] pc;
      logic        e_hit;
      logic        e_pred;
      logic [31:0] e_out;
   } vec_t;

   typedef struct {
      int          id;
      logic        hit;
      logic        pred;
      logic [31:0] out;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string name, input int id, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, id, act, exp);
      end
   endtask

   // Drive one cycle's inputs just after posedge, queue expected lookup result,
   // then compare at negedge before the update is clocked in.
   task automatic step(input int id, input vec_t v);
      exp_t e;
      @(posedge clk);
      #1;
      update_valid  = v.upd;
      update_pc     = v.upc;
      update_taken  = v.utk;
      update_target = v.utgt;
      mispredict    = v.mis;
      if_pc         = v.pc;
      sb.push_back('{id: id, hit: v.e_hit, pred: v.e_pred, out: v.e_out});
      @(negedge clk);
      if (sb.size() == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL scoreboard empty at step %0d", id);
      end else begin
         e = sb.pop_front();
         check("btb_hit", e.id, {31'd0, btb_hit}, {31'd0, e.hit});
         check("prediction", e.id, {31'd0, prediction}, {31'd0, e.pred});
         check("btb_out", e.id, btb_out, e.out);
      end
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      update_valid = 1'b0;
      mispredict   = 1'b0;
   endtask

   vec_t tbl[$];

   initial begin
      rst           = 1'b1;
      if_pc         = 32'h60;
      update_valid  = 1'b0;
      update_pc     = '0;
      update_taken  = 1'b0;
      update_target = '0;
      mispredict    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset btb_hit", -1, {31'd0, btb_hit}, 32'd0);
      check("reset prediction", -1, {31'd0, prediction}, 32'd0);
      check("reset btb_out", -1, btb_out, 32'h64);
      check("reset br_count", -1, br_count, 32'd0);
      check("reset mispred_count", -1, mispred_count, 32'd0);

      //          upd   upc       utk   utgt      mis   pc           hit   pred  out
      tbl.push_back('{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h60,      1'b0, 1'b0, 32'h64});
      tbl.push_back('{1'b1, 32'h60,  1'b1, 32'h100, 1'b0, 32'h60,      1'b0, 1'b0, 32'h64});
      tbl.push_back('{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h60,      1'b1, 1'b1, 32'h100});
      tbl.push_back('{1'b1, 32'h60,  1'b0, 32'h300, 1'b1, 32'h60,      1'b1, 1'b1, 32'h100});
      tbl.push_back('{1'b1, 32'h60,  1'b0, 32'h300, 1'b1, 32'h60,      1'b1, 1'b0, 32'h64});
      tbl.push_back('{1'b1, 32'h60,  1'b0, 32'h300, 1'b0, 32'h60,      1'b1, 1'b0, 32'h64});
      tbl.push_back('{1'b1, 32'h60,  1'b1, 32'h100, 1'b0, 32'h60,      1'b1, 1'b0, 32'h64});
      tbl.push_back('{1'b1, 32'h60,  1'b1, 32'h100, 1'b0, 32'h60,      1'b1, 1'b0, 32'h64});
      tbl.push_back('{1'b1, 32'h60,  1'b1, 32'h100, 1'b0, 32'h60,      1'b1, 1'b1, 32'h100});
      tbl.push_back('{1'b1, 32'h60,  1'b1, 32'h100, 1'b0, 32'h60,      1'b1, 1'b1, 32'h100});
      tbl.push_back('{1'b1, 32'h60,  1'b0, 32'h300, 1'b0, 32'h60,      1'b1, 1'b1, 32'h100});
      tbl.push_back('{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h60,      1'b1, 1'b1, 32'h100});
      tbl.push_back('{1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'hE0,      1'b0, 1'b0, 32'hE4});
      tbl.push_back('{1'b1, 32'hE0,  1'b0, 32'h200, 1'b0, 32'h60,      1'b1, 1'b1, 32'h100});
      tbl.push_back('{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h60,      1'b1, 1'b1, 32'h100});
      tbl.push_back('{1'b1, 32'hE0,  1'b1, 32'h200, 1'b0, 32'hE0,      1'b0, 1'b0, 32'hE4});
      tbl.push_back('{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'hE0,      1'b1, 1'b1, 32'h200});
      tbl.push_back('{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h60,      1'b0, 1'b0, 32'h64});
      tbl.push_back('{1'b1, 32'h10,  1'b1, 32'h400, 1'b0, 32'hE0,      1'b1, 1'b1, 32'h200});
      tbl.push_back('{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h10,      1'b1, 1'b1, 32'h400});
      tbl.push_back('{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'hFFFFFFFC, 1'b0, 1'b0, 32'h0});

      foreach (tbl[i]) step(i, tbl[i]);
      idle();
      @(negedge clk);
      // 12 updates in the table, two flagged mispredicts, one ignored flag.
      check("table br_count", 100, br_count, 32'd12);
      check("table mispred_count", 100, mispred_count, 32'd2);

      // Reset with a same-cycle taken update: update must be discarded.
      @(posedge clk);
      #1;
      rst           = 1'b1;
      update_valid  = 1'b1;
      update_pc     = 32'h80;
      update_taken  = 1'b1;
      update_target = 32'h500;
      mispredict    = 1'b1;
      @(posedge clk);
      #1;
      rst          = 1'b0;
      update_valid = 1'b0;
      mispredict   = 1'b0;
      if_pc        = 32'h80;
      @(negedge clk);
      check("rst+upd btb_hit", 200, {31'd0, btb_hit}, 32'd0);
      check("rst+upd btb_out", 200, btb_out, 32'h84);
      check("rst+upd br_count", 200, br_count, 32'd0);
      check("rst+upd mispred_count", 200, mispred_count, 32'd0);
      if_pc = 32'h10;
      #1;
      check("rst clears 0x10", 201, {31'd0, btb_hit}, 32'd0);

      // Three updates with one mispredict, plus a stray mispredict without valid.
      step(300, '{1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h40, 1'b0, 1'b0, 32'h44});
      step(301, '{1'b1, 32'h44, 1'b1, 32'h80, 1'b1, 32'h44, 1'b0, 1'b0, 32'h48});
      step(302, '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h44, 1'b1, 1'b1, 32'h80});
      step(303, '{1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h40, 1'b0, 1'b0, 32'h44});
      idle();
      @(negedge clk);
      check("perf br_count", 304, br_count, 32'd3);
      check("perf mispred_count", 304, mispred_count, 32'd1);

      if (sb.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL scoreboard leftover: got %0d entries expected 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
